// File: rtl/axis_hist_gen.sv
// rtl/axis_hist_gen.sv - streaming histogram: tags each sample with its bin count, dumps all bins on request.
// Optional build macro HIST_SAT_EN: counters saturate instead of wrapping.
module axis_hist_gen #(
   parameter int DATA_W        = 8,
   parameter int BIN_BITS      = 3,
   parameter int COUNT_W       = 16,
   parameter int CLEAR_ON_DUMP = 0
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [31:0]       m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   input  logic              dump_req,
   input  logic              clear_req,
   output logic              busy,
   output logic              overflow
);

   localparam int NUM_BINS = 1 << BIN_BITS;
   localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
   // Tag count field is halfword-aligned when {bin,value} fits below bit 16; bits above bit 29 are dropped.
   localparam int TAG_CNT_LSB  = (DATA_W + BIN_BITS <= 16) ? 16 : DATA_W + BIN_BITS;
   localparam int TAG_CNT_ROOM = 30 - TAG_CNT_LSB;
   localparam int TAG_CNT_W    = (COUNT_W < TAG_CNT_ROOM) ? COUNT_W : TAG_CNT_ROOM;
   localparam logic [BIN_BITS:0] IDX_END  = (BIN_BITS+1)'(NUM_BINS);
   localparam logic [BIN_BITS:0] IDX_LAST = (BIN_BITS+1)'(NUM_BINS - 1);

   generate
      if (DATA_W < 4 || DATA_W > 16 || BIN_BITS < 1 || BIN_BITS > 5 || COUNT_W < 1 ||
          DATA_W + BIN_BITS + COUNT_W > 30) begin : g_bad_cfg
         $fatal(1, "axis_hist_gen: unsupported parameter combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_DUMP
   } state_t;

   state_t              state_q, state_d;
   logic [COUNT_W-1:0]  bins_q [NUM_BINS];
   logic [COUNT_W-1:0]  bins_d [NUM_BINS];
   logic [31:0]         out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [BIN_BITS:0]   dump_idx_q, dump_idx_d;
   logic                overflow_q, overflow_d;

   logic [BIN_BITS-1:0] in_bin;
   logic [COUNT_W-1:0]  in_cnt;
   logic [COUNT_W-1:0]  inc_cnt;
   logic                inc_wrap;
   logic                out_fire;
   logic                out_free;
   logic                accept;
   logic [BIN_BITS-1:0] dump_bin;
   logic [BIN_BITS-1:0] sent_bin;
   logic [31:0]         tag_word;
   logic [31:0]         dump_word;

   assign in_bin   = s_axis_tdata[DATA_W-1 -: BIN_BITS];
   assign in_cnt   = bins_q[in_bin];
   assign inc_wrap = (in_cnt == CNT_MAX);
`ifdef HIST_SAT_EN
   assign inc_cnt  = inc_wrap ? CNT_MAX : in_cnt + 1'b1;
`else
   assign inc_cnt  = in_cnt + 1'b1;
`endif

   assign out_fire      = out_valid_q && m_axis_tready;
   assign out_free      = !out_valid_q || m_axis_tready;
   assign s_axis_tready = (state_q == ST_RUN) && !clear_req && out_free;
   assign accept        = s_axis_tvalid && s_axis_tready;

   assign dump_bin = dump_idx_q[BIN_BITS-1:0];
   // While in DUMP the output register always holds the bin one behind the load index.
   assign sent_bin = dump_bin - 1'b1;

   always_comb begin
      tag_word = '0;
      tag_word[31:30] = 2'b01;
      tag_word[TAG_CNT_LSB +: TAG_CNT_W] = inc_cnt[TAG_CNT_W-1:0];
      tag_word[DATA_W +: BIN_BITS] = in_bin;
      tag_word[DATA_W-1:0] = s_axis_tdata;
   end

   always_comb begin
      dump_word = '0;
      dump_word[31:30] = 2'b10;
      dump_word[COUNT_W +: BIN_BITS] = dump_bin;
      dump_word[COUNT_W-1:0] = bins_q[dump_bin];
   end

   always_comb begin
      state_d     = state_q;
      bins_d      = bins_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      dump_idx_d  = dump_idx_q;
      overflow_d  = overflow_q;

      case (state_q)
         ST_RUN: begin
            dump_idx_d = '0;
            if (dump_req) begin
               state_d = ST_DRAIN;
            end else if (clear_req) begin
               for (int i = 0; i < NUM_BINS; i++) begin
                  bins_d[i] = '0;
               end
               overflow_d = 1'b0;
            end
            if (accept) begin
               bins_d[in_bin] = inc_cnt;
               if (inc_wrap) begin
                  overflow_d = 1'b1;
               end
               out_data_d  = tag_word;
               out_valid_d = 1'b1;
               out_last_d  = 1'b1;
            end else if (out_fire) begin
               out_valid_d = 1'b0;
            end
         end

         ST_DRAIN: begin
            if (out_fire) begin
               out_valid_d = 1'b0;
            end
            if (!out_valid_q) begin
               state_d = ST_DUMP;
            end
         end

         ST_DUMP: begin
            if (out_fire && (CLEAR_ON_DUMP != 0)) begin
               bins_d[sent_bin] = '0;
            end
            if (out_free && (dump_idx_q != IDX_END)) begin
               out_data_d  = dump_word;
               out_valid_d = 1'b1;
               out_last_d  = (dump_idx_q == IDX_LAST);
               dump_idx_d  = dump_idx_q + 1'b1;
            end else if (out_fire) begin
               out_valid_d = 1'b0;
               if (out_last_q) begin
                  out_last_d = 1'b0;
                  state_d    = ST_RUN;
               end
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= ST_RUN;
         for (int i = 0; i < NUM_BINS; i++) begin
            bins_q[i] <= '0;
         end
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         dump_idx_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bins_q      <= bins_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         dump_idx_q  <= dump_idx_d;
         overflow_q  <= overflow_d;
      end
   end

   assign m_axis_tdata  = out_data_q;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tlast  = out_last_q;
   assign busy          = (state_q != ST_RUN);
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_axis_hist_gen.sv
// tb/tb_axis_hist_gen.sv - lockstep bench for a default instance and a COUNT_W=4 / CLEAR_ON_DUMP=1 instance.
module tb_axis_hist_gen;

   logic        aclk = 1'b0;
   logic        areset;
   logic [7:0]  s_tdata;
   logic        s_tvalid, m_tready, dump_req, clear_req;
   logic        s_tready0, mv0, ml0, busy0, ovf0;
   logic        s_tready1, mv1, ml1, busy1, ovf1;
   logic [31:0] md0, md1;

   int checks = 0;
   int errors = 0;

   int          mb0 [8];
   int          mb1 [8];
   bit          mo0, mo1;
   bit          exp_valid;
   logic [31:0] exp_d0, exp_d1;

   localparam int MAX0 = 65535;
   localparam int MAX1 = 15;

   always #5 aclk = ~aclk;

   axis_hist_gen u_dut0 (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0),
      .m_axis_tdata(md0), .m_axis_tvalid(mv0), .m_axis_tready(m_tready), .m_axis_tlast(ml0),
      .dump_req(dump_req), .clear_req(clear_req), .busy(busy0), .overflow(ovf0)
   );

   axis_hist_gen #(.DATA_W(8), .BIN_BITS(3), .COUNT_W(4), .CLEAR_ON_DUMP(1)) u_dut1 (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready1),
      .m_axis_tdata(md1), .m_axis_tvalid(mv1), .m_axis_tready(m_tready), .m_axis_tlast(ml1),
      .dump_req(dump_req), .clear_req(clear_req), .busy(busy1), .overflow(ovf1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Sample tag: 01 at the top, count from bit 16, bin from bit 8, value in the low byte.
   function automatic logic [31:0] tag_word(input int v, input int cnt, input int cw);
      int cf;
      cf = (cw < 14) ? cw : 14;
      return 32'h4000_0000 | ((cnt % (1 << cf)) << 16) | ((v / 32) << 8) | v;
   endfunction

   function automatic logic [31:0] dump_word(input int b, input int cnt, input int cw);
      return 32'h8000_0000 | (b << cw) | cnt;
   endfunction

   function automatic int bump(input int c, input int maxv);
`ifdef HIST_SAT_EN
      return (c == maxv) ? maxv : c + 1;
`else
      return (c == maxv) ? 0 : c + 1;
`endif
   endfunction

   task automatic zero_model();
      for (int i = 0; i < 8; i++) begin
         mb0[i] = 0;
         mb1[i] = 0;
      end
      mo0 = 0;
      mo1 = 0;
      exp_valid = 0;
   endtask

   task automatic do_reset();
      areset = 1; s_tvalid = 0; s_tdata = 0; m_tready = 1; dump_req = 0; clear_req = 0;
      repeat (2) @(posedge aclk);
      #1;
      zero_model();
      chk("rst_tvalid0", mv0, 0);   chk("rst_tvalid1", mv1, 0);
      chk("rst_tdata0", md0, 0);    chk("rst_tdata1", md1, 0);
      chk("rst_tlast0", ml0, 0);    chk("rst_tlast1", ml1, 0);
      chk("rst_busy0", busy0, 0);   chk("rst_busy1", busy1, 0);
      chk("rst_ovf0", ovf0, 0);     chk("rst_ovf1", ovf1, 0);
      areset = 0;
   endtask

   task automatic step_sample(input bit v, input int d, input bit rdy, input bit clr);
      bit er;
      int b;
      s_tvalid = v; s_tdata = d[7:0]; m_tready = rdy; clear_req = clr; dump_req = 0;
      #1;
      er = !clr && (!exp_valid || rdy);
      chk("s_tready0", s_tready0, er);
      chk("s_tready1", s_tready1, er);
      if (clr) begin
         for (int i = 0; i < 8; i++) begin
            mb0[i] = 0;
            mb1[i] = 0;
         end
         mo0 = 0;
         mo1 = 0;
      end
      if (v && er) begin
         b = d / 32;
         if (mb0[b] == MAX0) mo0 = 1;
         if (mb1[b] == MAX1) mo1 = 1;
         mb0[b] = bump(mb0[b], MAX0);
         mb1[b] = bump(mb1[b], MAX1);
         exp_d0 = tag_word(d, mb0[b], 16);
         exp_d1 = tag_word(d, mb1[b], 4);
         exp_valid = 1;
      end else if (exp_valid && rdy) begin
         exp_valid = 0;
      end
      @(posedge aclk);
      #1;
      s_tvalid = 0; clear_req = 0;
      chk("tvalid0", mv0, exp_valid);
      chk("tvalid1", mv1, exp_valid);
      if (exp_valid) begin
         chk("tag0", md0, exp_d0);
         chk("tag1", md1, exp_d1);
         chk("tag_last0", ml0, 1);
         chk("tag_last1", ml1, 1);
      end
      chk("ovf0", ovf0, mo0);
      chk("ovf1", ovf1, mo1);
   endtask

   task automatic run_dump(input bit do_clear, input int abort_at);
      logic [31:0] q0 [$];
      logic [31:0] q1 [$];
      bit          ql [$];
      int          idx;
      bit          aborted;
      idx = 0;
      aborted = 0;
      if (exp_valid) begin
         q0.push_back(exp_d0); q1.push_back(exp_d1); ql.push_back(1);
      end
      for (int b = 0; b < 8; b++) begin
         q0.push_back(dump_word(b, mb0[b], 16));
         q1.push_back(dump_word(b, mb1[b], 4));
         ql.push_back(b == 7);
      end
      for (int cyc = 0; cyc < 400 && idx < q0.size(); cyc++) begin
         dump_req  = (cyc == 0);
         clear_req = (cyc == 0) && do_clear;
         m_tready  = ($urandom_range(0, 3) != 0);
         s_tvalid  = (cyc != 0);
         s_tdata   = 8'($urandom);
         #1;
         if (cyc != 0) begin
            chk("dump_busy0", busy0, 1);
            chk("dump_busy1", busy1, 1);
            chk("dump_s_tready0", s_tready0, 0);
            chk("dump_s_tready1", s_tready1, 0);
         end
         if (abort_at >= 0 && idx == abort_at) begin
            areset = 1;
            aborted = 1;
            break;
         end
         if (mv0 && m_tready) begin
            chk("dump_word0", md0, q0[idx]);
            chk("dump_word1", md1, q1[idx]);
            chk("dump_last0", ml0, ql[idx]);
            chk("dump_last1", ml1, ql[idx]);
            idx++;
         end
         @(posedge aclk);
         #1;
      end
      dump_req = 0; clear_req = 0; s_tvalid = 0; exp_valid = 0;
      if (aborted) begin
         @(posedge aclk);
         #1;
         areset = 0;
         zero_model();
         chk("abort_tvalid0", mv0, 0); chk("abort_tvalid1", mv1, 0);
         chk("abort_tdata0", md0, 0);  chk("abort_tdata1", md1, 0);
         chk("abort_tlast0", ml0, 0);  chk("abort_tlast1", ml1, 0);
         chk("abort_busy0", busy0, 0); chk("abort_busy1", busy1, 0);
      end else begin
         chk("dump_words_seen", idx, q0.size());
         chk("dump_end_busy0", busy0, 0);
         chk("dump_end_busy1", busy1, 0);
         chk("dump_end_tvalid0", mv0, 0);
         chk("dump_end_tvalid1", mv1, 0);
         for (int b = 0; b < 8; b++) mb1[b] = 0;
      end
   endtask

   initial begin
      do_reset();

      step_sample(1, 'h05, 1, 0);
      chk("first_tag", md0, 32'h4001_0005);
      step_sample(1, 'h07, 1, 0);
      chk("second_tag", md0, 32'h4002_0007);
      step_sample(1, 'hE0, 1, 0);
      chk("third_tag", md0, 32'h4001_07E0);

      step_sample(1, 'h23, 0, 0);
      repeat (3) step_sample(1, 'h24, 0, 0);
      step_sample(0, 0, 1, 0);

      repeat (300) step_sample($urandom_range(0, 1) == 1, $urandom_range(0, 255),
                               $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
      run_dump(0, -1);

      do_reset();
      for (int i = 0; i < 10; i++) step_sample(1, 'h40 + i, 1, 0);
      run_dump(0, -1);

      do_reset();
      for (int i = 0; i < 16; i++) step_sample(1, i, 1, 0);
      chk("ovf_small", ovf1, 1);
      chk("ovf_default", ovf0, 0);
`ifdef HIST_SAT_EN
      chk("count16_small", md1[19:16], 15);
`else
      chk("count16_small", md1[19:16], 0);
`endif
      step_sample(0, 0, 1, 1);
      step_sample(1, 3, 1, 0);

      repeat (200) step_sample($urandom_range(0, 1) == 1,
                               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 31),
                               $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      run_dump(0, -1);

      step_sample(1, 'h01, 1, 0);
      step_sample(1, 'h21, 1, 0);
      step_sample(1, 'h22, 1, 0);
      step_sample(0, 0, 1, 0);
      run_dump(1, 2);
      run_dump(0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
